// File: rtl/axil_ram_port.sv
// AXI-Lite slave front end for a single-port RAM array; one array access per cycle.
// Latency: write response 1 cycle after accept, read data 1 cycle (2 with PIPELINE_OUTPUT=1).
// Backpressure: awready/wready/arready are combinational grants, held off while the response slot is full.
module axil_ram_port #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int PIPELINE_OUTPUT = 0,
    localparam int SW_LOG         = $clog2(STRB_WIDTH),
    localparam int WORD_AW        = ADDR_WIDTH - SW_LOG
) (
    input  logic                  a_clk,
    input  logic                  a_rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [WORD_AW-1:0]    mem_addr,
    output logic                  mem_wr_en,
    output logic [STRB_WIDTH-1:0] mem_wr_strb,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    logic                  bvalid_q, bvalid_d;
    logic                  rvalid_q, rvalid_d;
    logic                  stage_q, stage_d;
    logic                  last_rd_q, last_rd_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic wr_elig, rd_elig, rd_slot, wr_acc, rd_acc;

    // Grants are masked by reset so no handshake or array access leaks out while held in reset.
    assign rd_slot = (~rvalid_q | s_axil_rready) & ((PIPELINE_OUTPUT != 0) ? ~stage_q : 1'b1);
    assign wr_elig = a_rst & s_axil_awvalid & s_axil_wvalid & (~bvalid_q | s_axil_bready);
    assign rd_elig = a_rst & s_axil_arvalid & rd_slot;
    assign wr_acc  = wr_elig & (~rd_elig | last_rd_q);
    assign rd_acc  = rd_elig & ~wr_acc;

    assign s_axil_awready = wr_acc;
    assign s_axil_wready  = wr_acc;
    assign s_axil_arready = rd_acc;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = 2'b00;

    assign mem_wr_en   = wr_acc;
    assign mem_rd_en   = rd_acc;
    assign mem_wr_strb = wr_acc ? s_axil_wstrb : '0;
    assign mem_wr_data = wr_acc ? s_axil_wdata : '0;
    assign mem_addr    = wr_acc ? s_axil_awaddr[ADDR_WIDTH-1:SW_LOG]
                                : s_axil_araddr[ADDR_WIDTH-1:SW_LOG];

    // Without the output stage the first beat comes straight from the array, later beats from the hold register.
    assign s_axil_rdata = ((PIPELINE_OUTPUT == 0) && stage_q) ? mem_rd_data : rdata_q;

    always_comb begin
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        stage_d   = rd_acc;
        last_rd_d = last_rd_q;
        rdata_d   = rdata_q;
        if (wr_acc) begin
            bvalid_d = 1'b1;
        end else if (s_axil_bready) begin
            bvalid_d = 1'b0;
        end
        rvalid_d = ((PIPELINE_OUTPUT != 0) ? stage_q : rd_acc) | (rvalid_q & ~s_axil_rready);
        if (stage_q) begin
            rdata_d = mem_rd_data;
        end
        if (wr_acc) begin
            last_rd_d = 1'b0;
        end else if (rd_acc) begin
            last_rd_d = 1'b1;
        end
    end

    always_ff @(posedge a_clk or negedge a_rst) begin
        if (!a_rst) begin
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            stage_q   <= 1'b0;
            last_rd_q <= 1'b1;
            rdata_q   <= '0;
        end else begin
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            stage_q   <= stage_d;
            last_rd_q <= last_rd_d;
            rdata_q   <= rdata_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[SW_LOG-1:0], s_axil_araddr[SW_LOG-1:0]};

endmodule

// File: doc/axil_ram_port.md
AXIL_RAM_PORT -- requirements
Module: axil_ram_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, AXI-Lite byte address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write strobe width.
REQ-004 SHALL have parameter PIPELINE_OUTPUT, default 0, adds one register stage on read data when 1.
REQ-005 SHALL define WORD_AW = ADDR_WIDTH - log2(STRB_WIDTH) as a local parameter.
REQ-006 a_clk  in  1  single clock; all logic on rising edge.
REQ-007 a_rst  in  1  asynchronous, active-low reset.
REQ-008 s_axil_awaddr  in  ADDR_WIDTH  write address; s_axil_awprot  in  3  ignored.
REQ-009 s_axil_awvalid  in  1  / s_axil_awready  out  1  write address handshake.
REQ-010 s_axil_wdata  in  DATA_WIDTH; s_axil_wstrb  in  STRB_WIDTH  write data/byte enables.
REQ-011 s_axil_wvalid  in  1  / s_axil_wready  out  1  write data handshake.
REQ-012 s_axil_bresp  out  2; s_axil_bvalid  out  1; s_axil_bready  in  1  write response.
REQ-013 s_axil_araddr  in  ADDR_WIDTH; s_axil_arprot  in  3 (ignored); s_axil_arvalid  in  1; s_axil_arready  out  1.
REQ-014 s_axil_rdata  out  DATA_WIDTH; s_axil_rresp  out  2; s_axil_rvalid  out  1; s_axil_rready  in  1.
REQ-015 mem_addr  out  WORD_AW  word address to RAM array port.
REQ-016 mem_wr_en  out  1; mem_wr_strb  out  STRB_WIDTH; mem_wr_data  out  DATA_WIDTH  array write.
REQ-017 mem_rd_en  out  1; mem_rd_data  in  DATA_WIDTH  valid one cycle after mem_rd_en.

Function
REQ-018 Write accept SHALL require awvalid AND wvalid AND write grant AND (bvalid=0 OR bready=1); awready and wready SHALL assert together in that cycle only.
REQ-019 On write accept: mem_wr_en=1 same cycle, mem_addr=awaddr[ADDR_WIDTH-1:log2(STRB_WIDTH)], mem_wr_strb=wstrb, mem_wr_data=wdata.
REQ-020 bvalid SHALL rise the cycle after write accept, bresp=2'b00, held until bready.
REQ-021 Read accept SHALL require arvalid AND read grant AND output slot free (rvalid=0 OR rready=1, plus empty pipeline stage when PIPELINE_OUTPUT=1); arready asserts that cycle only.
REQ-022 On read accept: mem_rd_en=1 same cycle, mem_addr=araddr word index.
REQ-023 rvalid SHALL rise 1 cycle after accept (PIPELINE_OUTPUT=0) or 2 cycles (=1); rresp=2'b00.
REQ-024 rdata SHALL stay stable while rvalid=1 and rready=0.
REQ-025 Single array port: if write and read both eligible same cycle, a last_was_read flag SHALL grant write when 1, read when 0; flag updates on every accept.
REQ-026 Eligible-alone requests SHALL be granted without waiting for alternation.
REQ-027 Back-to-back: with bready/rready held 1, one accept per cycle SHALL be sustained.
REQ-028 mem_wr_en and mem_rd_en SHALL never be 1 in the same cycle.
REQ-029 Address bits below log2(STRB_WIDTH) SHALL be ignored; no response other than OKAY.

Reset
REQ-030 a_rst=0 SHALL asynchronously clear awready, wready, arready, bvalid, rvalid, mem_wr_en, mem_rd_en to 0, rdata to 0, bresp/rresp to 0, last_was_read to 1.
REQ-031 Reset mid-transaction SHALL drop pending responses; no mem access after deassert until a new handshake.
REQ-032 First rising edge after a_rst deasserts SHALL be able to accept a transaction.

Verification
REQ-033 Write 0xDEADBEEF to 0x0010, strb 0xF -> mem_wr_en 1 cycle, mem_addr=0x0004, bvalid next cycle, bresp=00.
REQ-034 Write 0x000000AA strb 0x1 to 0x0010 then read 0x0010 -> rdata=0xDEADBEAA, rvalid 1 cycle after arready (2 with PIPELINE_OUTPUT=1).
REQ-035 awvalid/wvalid/arvalid asserted together from reset -> write granted first, read next cycle, no overlapping mem enables.
REQ-036 rready held 0 for 5 cycles after rvalid -> rdata stable, arready stays 0 for a second pending read.
REQ-037 a_rst pulsed low while bvalid=1 -> bvalid 0 immediately, no response after release.
